digit_classifier: RTL

//  Output stage of the digit-recognition network. On network_done from the network controller,

---
 rtl/nn_pkg.sv | 17 +
 rtl/flex_counter.sv | 34 +++
 rtl/digit_classifier.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// Shared types and constants for the digit-recognition network.
// The classifier FSM states live here so the network controller can decode them too.
package nn_pkg;

   localparam int NUM_CLASSES   = 10;
   localparam int OUT_BASE_ADDR = 8;
   localparam int DATA_W        = 4;
   localparam int ADDR_W        = 5;

   typedef enum logic [1:0] {
      CLF_IDLE  = 2'd0,
      CLF_SCAN  = 2'd1,
      CLF_DRAIN = 2'd2,
      CLF_HOLD  = 2'd3
   } clf_state_t;

endpackage

// File: rtl/flex_counter.sv
// Parameterised up-counter: counts 0..rollover_val, then wraps to 0.
// rollover_flag is high while the count equals rollover_val.
module flex_counter #(
   parameter int NUM_CNT_BITS = 4
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    clear,
   input  logic                    count_enable,
   input  logic [NUM_CNT_BITS-1:0] rollover_val,
   output logic [NUM_CNT_BITS-1:0] count_out,
   output logic                    rollover_flag
);

   logic [NUM_CNT_BITS-1:0] r_count;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_count <= '0;
      end else if (clear) begin
         r_count <= '0;
      end else if (count_enable) begin
         if (r_count == rollover_val) begin
            r_count <= '0;
         end else begin
            r_count <= r_count + 1'b1;
         end
      end
   end

   assign count_out     = r_count;
   assign rollover_flag = (r_count == rollover_val);

endmodule

// File: rtl/digit_classifier.sv
// Network output stage: argmax over the layer-2 activations in sigmoid memory,
// presenting the winning digit and its confidence under a valid/ack handshake.
module digit_classifier
   import nn_pkg::*;
#(
   parameter int NUM_CLASSES   = nn_pkg::NUM_CLASSES,
   parameter int OUT_BASE_ADDR = nn_pkg::OUT_BASE_ADDR,
   parameter int DATA_W        = nn_pkg::DATA_W,
   parameter int ADDR_W        = nn_pkg::ADDR_W,
   parameter int RD_LATENCY    = 0
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              network_done,
   input  logic [DATA_W-1:0] sig_data,
   output logic [ADDR_W-1:0] sig_addr,
   output logic              sig_rd,
   output logic [3:0]        digit,
   output logic [DATA_W-1:0] confidence,
   output logic              result_valid,
   input  logic              result_ack,
   output logic              busy,
   output logic              overrun_err
);

   localparam int CNT_W = $clog2(NUM_CLASSES);

   clf_state_t        r_state;
   clf_state_t        w_state_nxt;
   logic [CNT_W-1:0]  w_idx;
   logic              w_last;
   logic              w_cmp_v;
   logic [CNT_W-1:0]  w_cmp_idx;
   logic [DATA_W-1:0] r_max;
   logic [DATA_W-1:0] w_max_nxt;
   logic [CNT_W-1:0]  r_best;
   logic [CNT_W-1:0]  w_best_nxt;
   logic [3:0]        r_digit;
   logic [DATA_W-1:0] r_conf;
   logic              r_err;
   logic              w_overrun;

   flex_counter #(
      .NUM_CNT_BITS(CNT_W)
   ) u_idx_cnt (
      .clk          (clk),
      .n_rst        (n_rst),
      .clear        (r_state != CLF_SCAN),
      .count_enable (r_state == CLF_SCAN),
      .rollover_val (CNT_W'(NUM_CLASSES - 1)),
      .count_out    (w_idx),
      .rollover_flag(w_last)
   );

   assign sig_rd       = (r_state == CLF_SCAN);
   assign sig_addr     = sig_rd ? (ADDR_W'(OUT_BASE_ADDR) + ADDR_W'(w_idx)) : '0;
   assign busy         = (r_state == CLF_SCAN) || (r_state == CLF_DRAIN);
   assign result_valid = (r_state == CLF_HOLD);
   assign digit        = r_digit;
   assign confidence   = r_conf;
   assign overrun_err  = r_err;

   // A done during a scan, or over an un-acked result, is an overrun.
   assign w_overrun = network_done &&
                      (busy || ((r_state == CLF_HOLD) && !result_ack));

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         CLF_IDLE:  if (network_done) w_state_nxt = CLF_SCAN;
         CLF_SCAN:  if (w_last) w_state_nxt = (RD_LATENCY == 0) ? CLF_HOLD : CLF_DRAIN;
         CLF_DRAIN: w_state_nxt = CLF_HOLD;
         CLF_HOLD: begin
            if (network_done) begin
               w_state_nxt = CLF_SCAN;
            end else if (result_ack) begin
               w_state_nxt = CLF_IDLE;
            end
         end
         default:   w_state_nxt = CLF_IDLE;
      endcase
   end

   // Read data returns RD_LATENCY cycles after the address; delay valid/idx to match.
   generate
      if (RD_LATENCY == 0) begin : g_no_delay
         assign w_cmp_v   = sig_rd;
         assign w_cmp_idx = w_idx;
      end else begin : g_delay
         logic             r_pv   [RD_LATENCY];
         logic [CNT_W-1:0] r_pidx [RD_LATENCY];

         always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
               for (int unsigned i = 0; i < unsigned'(RD_LATENCY); i++) begin
                  r_pv[i]   <= 1'b0;
                  r_pidx[i] <= '0;
               end
            end else begin
               r_pv[0]   <= sig_rd;
               r_pidx[0] <= w_idx;
               for (int unsigned i = 1; i < unsigned'(RD_LATENCY); i++) begin
                  r_pv[i]   <= r_pv[i-1];
                  r_pidx[i] <= r_pidx[i-1];
               end
            end
         end

         assign w_cmp_v   = r_pv[RD_LATENCY-1];
         assign w_cmp_idx = r_pidx[RD_LATENCY-1];
      end
   endgenerate

   // Class 0 seeds the running max; strict compare keeps ties on the lowest index.
   always_comb begin
      w_max_nxt  = r_max;
      w_best_nxt = r_best;
      if (w_cmp_v && ((w_cmp_idx == '0) || (sig_data > r_max))) begin
         w_max_nxt  = sig_data;
         w_best_nxt = w_cmp_idx;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state <= CLF_IDLE;
         r_max   <= '0;
         r_best  <= '0;
         r_digit <= '0;
         r_conf  <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_max   <= w_max_nxt;
         r_best  <= w_best_nxt;
         r_err   <= r_err | w_overrun;
         // Publish only on entry to HOLD so the outputs never show a partial scan.
         if ((w_state_nxt == CLF_HOLD) && (r_state != CLF_HOLD)) begin
            r_digit <= 4'(w_best_nxt);
            r_conf  <= w_max_nxt;
         end
      end
   end

endmodule
